jtag_cmd_sequencer: RTL and testbench
=====================================

# jtag_cmd_sequencer

Command/response sequencer that sits directly downstream of the JTAG register bank and turns host-written registers into single-shot requests for user logic. The host writes an argument and a command word, then flips a request toggle bit. The block waits for the words to settle, issues one valid/ready request, collects the response, and publishes result plus an acknowledge toggle back into the bank's readable registers. Register 0 carries command (host→FPGA) and status (FPGA→host); register 1 carries argument and result.

## Interface
- WIDTH, 32, register width; ≥16
- STABLE_CYCLES, 4, consecutive unchanged cycles required before a command is accepted; ≥1
- TIMEOUT_CYCLES, 65536, response timeout in WAIT; used only with JTAG_CMD_TIMEOUT_EN
- iMAIN_CLK  in  1  sole clock
- iRESET  in  1  synchronous, active-high reset
- iCMD  in  WIDTH  from bank oDATA[0]: [WIDTH-1] REQ toggle, [WIDTH-2:WIDTH-9] opcode, rest ignored
- iARG  in  WIDTH  from bank oDATA[1]
- oSTATUS  out  WIDTH  to bank iDATA[0]: [WIDTH-1] ACK toggle, [WIDTH-2:WIDTH-9] echoed opcode, [4] busy, [3:0] status code, other bits 0
- oRESULT  out  WIDTH  to bank iDATA[1]
- oREQ_VALID  out  1  request valid
- iREQ_READY  in  1  request accepted
- oREQ_OP  out  8  opcode
- oREQ_ARG  out  WIDTH  argument
- iRSP_VALID  in  1  single-cycle response strobe
- iRSP_DATA  in  WIDTH  response data
- iRSP_STATUS  in  4  response status code

## Operation
- States: RESYNC, IDLE, SETTLE, ISSUE, WAIT, DONE.
- Reset:
  - Enter RESYNC.
  - oSTATUS=0, oRESULT=0, oREQ_VALID=0, oREQ_OP=0, oREQ_ARG=0.
- RESYNC (one cycle):
  - ACK ← iCMD[WIDTH-1].
  - Go to IDLE.
  - A stale toggle left in the bank across reset is discarded, never executed.
- IDLE:
  - When iCMD[WIDTH-1] ≠ ACK: snapshot iCMD and iARG, clear the settle counter, go to SETTLE.
- SETTLE:
  - If iCMD or iARG differs from the snapshot: re-snapshot and clear the counter.
  - Otherwise increment the counter. At STABLE_CYCLES-1, go to ISSUE.
  - If the toggle reverts to equal ACK, return to IDLE with no request.
- ISSUE:
  - oREQ_VALID=1. oREQ_OP and oREQ_ARG come from the snapshot and are held constant while valid.
  - On iREQ_READY, go to WAIT.
- WAIT:
  - On iRSP_VALID: latch iRSP_DATA and iRSP_STATUS, go to DONE.
  - iRSP_VALID in any other state is ignored.
- DONE (one cycle), all in one register update:
  - oRESULT ← data.
  - oSTATUS code ← status, opcode ← echo, ACK ← ~ACK.
  - Go to IDLE.
- Busy bit:
  - Registered.
  - 1 in SETTLE/ISSUE/WAIT/DONE, 0 in RESYNC/IDLE.
- Host changes to iCMD/iARG after ISSUE are ignored until the next IDLE.

## Timing
- Mismatch sampled in IDLE at cycle N:
  - SETTLE occupies N+1 .. N+STABLE_CYCLES.
  - oREQ_VALID rises at N+STABLE_CYCLES+1.
- With ready and response both immediate, the ACK toggle and oRESULT are visible at N+STABLE_CYCLES+4. The default is N+8.
- oRESULT never changes in a cycle where ACK does not toggle, except on reset.
- Reset mid-operation:
  - oREQ_VALID is 0 the cycle after iRESET is sampled.
  - In-flight responses are dropped.
  - No ACK toggle is produced.

## Configuration
- JTAG_CMD_TIMEOUT_EN defined:
  - WAIT counts cycles.
  - After TIMEOUT_CYCLES cycles with no response: go to DONE with status 4'hE and result 0.
  - iRSP_VALID in the expiry cycle wins over the timeout.
- JTAG_CMD_TIMEOUT_EN undefined:
  - WAIT holds indefinitely.
  - No counter hardware.

## Structure
- Package jtag_cmd_pkg holds:
  - The state enum.
  - Field positions: REQ/ACK bit, opcode MSB/LSB, busy bit, status field.
  - Status constants STAT_OK=4'h0 and STAT_TIMEOUT=4'hE.
- Sub-module jtag_cmd_settle holds the snapshot register, comparator and settle counter. Its outputs are settled, snap_cmd and snap_arg.

## Test plan
- Post-reset stale toggle: hold iCMD[31]=1 through reset → ACK=1 after RESYNC, no oREQ_VALID within 50 cycles.
- Basic command: iARG=0x1234, opcode 0x05, flip REQ; iREQ_READY=1; response 0xCAFEF00D/status 0 on first WAIT cycle → oREQ_ARG=0x1234, oREQ_OP=0x05, oRESULT=0xCAFEF00D, oSTATUS[30:23]=0x05, ACK toggles at N+8.
- Unstable write: change iARG every 2 cycles for 20 cycles after toggle, then hold 0xAA → exactly one request, with ARG=0xAA.
- Backpressure: iREQ_READY low 10 cycles → oREQ_VALID, OP and ARG held constant throughout, single handshake.
- Reset in WAIT: iRESET for one cycle, then iRSP_VALID → oREQ_VALID=0, oSTATUS=0 aside from RESYNC ACK, oRESULT=0, response ignored.
- Timeout (JTAG_CMD_TIMEOUT_EN, TIMEOUT_CYCLES=16): no response → status 4'hE, oRESULT=0, ACK toggles; repeat with iRSP_VALID exactly at expiry → response status/data reported.

Source files
------------

// File: rtl/jtag_cmd_pkg.sv
// Shared types and field positions for the JTAG command sequencer.
// Status word layout: [W-1] ACK toggle, [W-2:W-9] echoed opcode,
// [4] busy, [3:0] status code; all other bits read as zero.
package jtag_cmd_pkg;

    typedef enum logic [2:0] {
        ST_RESYNC,
        ST_IDLE,
        ST_SETTLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_e;

    localparam int OP_W     = 8;
    localparam int STAT_W   = 4;
    localparam int BUSY_BIT = 4;
    localparam int STAT_MSB = 3;
    localparam int STAT_LSB = 0;

    localparam logic [STAT_W-1:0] STAT_OK      = 4'h0;
    localparam logic [STAT_W-1:0] STAT_TIMEOUT = 4'hE;

    // REQ toggle in the command word, ACK toggle in the status word
    function automatic int req_bit(input int width);
        return width - 1;
    endfunction

    function automatic int op_msb(input int width);
        return width - 2;
    endfunction

    function automatic int op_lsb(input int width);
        return width - 9;
    endfunction

endpackage

// File: rtl/jtag_cmd_settle.sv
// Snapshot register, comparator and settle counter. The host words must
// hold unchanged for STABLE_CYCLES consecutive SETTLE cycles before
// settled_o is raised; any change re-snapshots and restarts the count.
module jtag_cmd_settle
    import jtag_cmd_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int STABLE_CYCLES = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] cmd_i,
    input  logic [WIDTH-1:0] arg_i,
    output logic             settled_o,
    output logic [WIDTH-1:0] snap_cmd_o,
    output logic [WIDTH-1:0] snap_arg_o
);

    localparam int              CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] snap_cmd_q;
    logic [WIDTH-1:0] snap_arg_q;
    logic [CNT_W-1:0] cnt_q;
    logic             differ;

    assign differ = (cmd_i != snap_cmd_q) || (arg_i != snap_arg_q);

    // Capture the host words on entry and again whenever they move
    always_ff @(posedge clk_i) begin
        if (load_i || (en_i && differ)) begin
            snap_cmd_q <= cmd_i;
            snap_arg_q <= arg_i;
        end
    end

    // Count consecutive unchanged cycles; any change restarts the count
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            if (differ) begin
                cnt_q <= '0;
            end else if (cnt_q != CNT_LAST) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign settled_o  = en_i && !differ && (cnt_q == CNT_LAST);
    assign snap_cmd_o = snap_cmd_q;
    assign snap_arg_o = snap_arg_q;

endmodule

// File: rtl/jtag_cmd_sequencer.sv
// Turns host-written JTAG bank registers into one valid/ready request per
// REQ toggle and publishes the response plus an ACK toggle back to the bank.
// Optional feature: define JTAG_CMD_TIMEOUT_EN to bound the response wait
// to TIMEOUT_CYCLES cycles (reported with status code 4'hE, result 0).
module jtag_cmd_sequencer
    import jtag_cmd_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic              iMAIN_CLK,
    input  logic              iRESET,
    input  logic [WIDTH-1:0]  iCMD,
    input  logic [WIDTH-1:0]  iARG,
    output logic [WIDTH-1:0]  oSTATUS,
    output logic [WIDTH-1:0]  oRESULT,
    output logic              oREQ_VALID,
    input  logic              iREQ_READY,
    output logic [OP_W-1:0]   oREQ_OP,
    output logic [WIDTH-1:0]  oREQ_ARG,
    input  logic              iRSP_VALID,
    input  logic [WIDTH-1:0]  iRSP_DATA,
    input  logic [STAT_W-1:0] iRSP_STATUS
);

    localparam int REQ_BIT = req_bit(WIDTH);
    localparam int OP_MSB  = op_msb(WIDTH);
    localparam int OP_LSB  = op_lsb(WIDTH);

    state_e            state_q;
    logic              ack_q;
    logic [OP_W-1:0]   echo_op_q;
    logic              busy_q;
    logic [STAT_W-1:0] code_q;
    logic [WIDTH-1:0]  result_q;
    logic              req_valid_q;
    logic [OP_W-1:0]   req_op_q;
    logic [WIDTH-1:0]  req_arg_q;
    logic [WIDTH-1:0]  rsp_data_q;
    logic [STAT_W-1:0] rsp_stat_q;

    logic              req_pending;
    logic              settle_load;
    logic              settle_en;
    logic              settled;
    logic [WIDTH-1:0]  snap_cmd;
    logic [WIDTH-1:0]  snap_arg;

`ifdef JTAG_CMD_TIMEOUT_EN
    localparam int              TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0] tmo_q;
`else
    localparam int unused_tmo = TIMEOUT_CYCLES;
`endif

    // A new command exists whenever the host toggle disagrees with ACK
    assign req_pending = (iCMD[REQ_BIT] != ack_q);
    assign settle_load = (state_q == ST_IDLE) && req_pending;
    assign settle_en   = (state_q == ST_SETTLE);

    jtag_cmd_settle #(
        .WIDTH         (WIDTH),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_settle (
        .clk_i      (iMAIN_CLK),
        .rst_i      (iRESET),
        .load_i     (settle_load),
        .en_i       (settle_en),
        .cmd_i      (iCMD),
        .arg_i      (iARG),
        .settled_o  (settled),
        .snap_cmd_o (snap_cmd),
        .snap_arg_o (snap_arg)
    );

    // Only the opcode field of the snapshot feeds the request
    logic unused_snap;
    assign unused_snap = ^{snap_cmd[REQ_BIT], snap_cmd[OP_LSB-1:0]};

    // Sequencer FSM with all bank-facing and request outputs registered
    always_ff @(posedge iMAIN_CLK) begin
        if (iRESET) begin
            state_q     <= ST_RESYNC;
            ack_q       <= 1'b0;
            echo_op_q   <= '0;
            busy_q      <= 1'b0;
            code_q      <= '0;
            result_q    <= '0;
            req_valid_q <= 1'b0;
            req_op_q    <= '0;
            req_arg_q   <= '0;
`ifdef JTAG_CMD_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            case (state_q)
                ST_RESYNC: begin
                    // Adopt whatever toggle survived reset so it is never run
                    ack_q   <= iCMD[REQ_BIT];
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (req_pending) begin
                        busy_q  <= 1'b1;
                        state_q <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (!req_pending) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (settled) begin
                        req_valid_q <= 1'b1;
                        req_op_q    <= snap_cmd[OP_MSB:OP_LSB];
                        req_arg_q   <= snap_arg;
                        state_q     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (iREQ_READY) begin
                        req_valid_q <= 1'b0;
                        state_q     <= ST_WAIT;
`ifdef JTAG_CMD_TIMEOUT_EN
                        tmo_q       <= '0;
`endif
                    end
                end
                ST_WAIT: begin
                    if (iRSP_VALID) begin
                        rsp_data_q <= iRSP_DATA;
                        rsp_stat_q <= iRSP_STATUS;
                        state_q    <= ST_DONE;
                    end
`ifdef JTAG_CMD_TIMEOUT_EN
                    else if (tmo_q == TMO_LAST) begin
                        rsp_data_q <= '0;
                        rsp_stat_q <= STAT_TIMEOUT;
                        state_q    <= ST_DONE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
`endif
                end
                ST_DONE: begin
                    // Result, status and ACK all change on the same edge
                    result_q  <= rsp_data_q;
                    code_q    <= rsp_stat_q;
                    echo_op_q <= req_op_q;
                    ack_q     <= ~ack_q;
                    busy_q    <= 1'b0;
                    state_q   <= ST_IDLE;
                end
                default: begin
                    req_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= ST_RESYNC;
                end
            endcase
        end
    end

    // Assemble the status word from its registered fields
    always_comb begin
        oSTATUS                    = '0;
        oSTATUS[REQ_BIT]           = ack_q;
        oSTATUS[OP_MSB:OP_LSB]     = echo_op_q;
        oSTATUS[BUSY_BIT]          = busy_q;
        oSTATUS[STAT_MSB:STAT_LSB] = code_q;
    end

    assign oRESULT    = result_q;
    assign oREQ_VALID = req_valid_q;
    assign oREQ_OP    = req_op_q;
    assign oREQ_ARG   = req_arg_q;

endmodule

// File: tb/tb_jtag_cmd_sequencer.sv
// Self-checking bench for jtag_cmd_sequencer: expected requests and
// responses are queued as stimulus is issued and checked when the DUT
// hands a request out or toggles ACK. Define JTAG_CMD_TIMEOUT_EN to also
// exercise the response timeout (TIMEOUT_CYCLES=16).
module tb_jtag_cmd_sequencer;

    typedef struct {
        logic [7:0]  op;
        logic [31:0] arg;
    } req_t;

    typedef struct {
        logic [7:0]  op;
        logic [3:0]  stat;
        logic [31:0] data;
    } rsp_t;

    logic        clk = 1'b0;
    logic        iRESET;
    logic [31:0] iCMD;
    logic [31:0] iARG;
    logic [31:0] oSTATUS;
    logic [31:0] oRESULT;
    logic        oREQ_VALID;
    logic        iREQ_READY;
    logic [7:0]  oREQ_OP;
    logic [31:0] oREQ_ARG;
    logic        iRSP_VALID;
    logic [31:0] iRSP_DATA;
    logic [3:0]  iRSP_STATUS;

    req_t exp_req[$];
    rsp_t exp_rsp[$];

    int   n_chk  = 0;
    int   n_fail = 0;
    int   hs_cnt = 0;
    logic mon_on = 1'b0;
    logic host_req;

    logic        rsp_en    = 1'b0;
    int          rsp_delay = 0;
    logic [31:0] rsp_data  = '0;
    logic [3:0]  rsp_stat  = '0;

    always #5 clk = ~clk;

    jtag_cmd_sequencer #(
        .WIDTH          (32),
        .STABLE_CYCLES  (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .iMAIN_CLK   (clk),
        .iRESET      (iRESET),
        .iCMD        (iCMD),
        .iARG        (iARG),
        .oSTATUS     (oSTATUS),
        .oRESULT     (oRESULT),
        .oREQ_VALID  (oREQ_VALID),
        .iREQ_READY  (iREQ_READY),
        .oREQ_OP     (oREQ_OP),
        .oREQ_ARG    (oREQ_ARG),
        .iRSP_VALID  (iRSP_VALID),
        .iRSP_DATA   (iRSP_DATA),
        .iRSP_STATUS (iRSP_STATUS)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Flip the REQ toggle with a new command, then track valid and ACK timing
    task automatic send_cmd(input logic [7:0] op, input logic [31:0] arg,
                            output int t_valid, output int t_ack);
        host_req = ~host_req;
        iCMD     = {host_req, op, 23'h0};
        iARG     = arg;
        t_valid  = -1;
        t_ack    = -1;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk); #1;
            if (i == 1) chk("busy_in_settle", oSTATUS[4], 1'b1);
            if (oREQ_VALID && t_valid < 0) t_valid = i;
            if (oSTATUS[31] == host_req) begin
                t_ack = i;
                break;
            end
        end
        if (t_ack < 0) chk("ack_wait_expired", 1'b0, 1'b1);
        else           chk("busy_after_ack", oSTATUS[4], 1'b0);
    endtask

    task automatic wait_ack(input string tag);
        int got;
        got = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (oSTATUS[31] == host_req) begin
                got = 1;
                break;
            end
        end
        chk(tag, got, 1);
    endtask

    // Response model: answers each handshake after rsp_delay WAIT cycles
    initial begin
        iRSP_VALID  = 1'b0;
        iRSP_DATA   = '0;
        iRSP_STATUS = '0;
        forever begin
            @(negedge clk);
            if (oREQ_VALID && iREQ_READY && rsp_en) begin
                @(posedge clk); #1;
                repeat (rsp_delay) begin
                    @(posedge clk); #1;
                end
                iRSP_VALID  = 1'b1;
                iRSP_DATA   = rsp_data;
                iRSP_STATUS = rsp_stat;
                @(posedge clk); #1;
                iRSP_VALID  = 1'b0;
            end
        end
    end

    // Scoreboard: compare requests at handshake and results at ACK toggle
    initial begin
        logic        prev_ack;
        logic [31:0] prev_res;
        logic        tog;
        req_t        r;
        rsp_t        p;
        prev_ack = 1'b0;
        prev_res = '0;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                if (oREQ_VALID && iREQ_READY) begin
                    hs_cnt++;
                    if (exp_req.size() == 0) begin
                        chk("unexpected_request", 1'b1, 1'b0);
                    end else begin
                        r = exp_req.pop_front();
                        chk("req_op", oREQ_OP, r.op);
                        chk("req_arg", oREQ_ARG, r.arg);
                    end
                end
                tog = (oSTATUS[31] != prev_ack);
                if (tog) begin
                    if (exp_rsp.size() == 0) begin
                        chk("unexpected_ack", 1'b1, 1'b0);
                    end else begin
                        p = exp_rsp.pop_front();
                        chk("rsp_result", oRESULT, p.data);
                        chk("rsp_code", oSTATUS[3:0], p.stat);
                        chk("rsp_echo_op", oSTATUS[30:23], p.op);
                    end
                end else if (oRESULT != prev_res) begin
                    chk("result_changed_without_ack", 1'b0, 1'b1);
                end
            end
            prev_ack = oSTATUS[31];
            prev_res = oRESULT;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int tv, ta, vcnt, hs0;
        logic held_ack;

        iRESET     = 1'b1;
        iCMD       = 32'h8000_0000;
        iARG       = '0;
        iREQ_READY = 1'b1;
        host_req   = 1'b1;

        // Reset with a stale toggle left in the bank
        repeat (3) @(posedge clk);
        #1;
        chk("reset_status", oSTATUS, 32'h0);
        chk("reset_result", oRESULT, 32'h0);
        chk("reset_valid", oREQ_VALID, 1'b0);
        chk("reset_op", oREQ_OP, 8'h0);
        chk("reset_arg", oREQ_ARG, 32'h0);
        iRESET = 1'b0;
        @(posedge clk); #1;
        chk("stale_ack_adopted", oSTATUS[31], 1'b1);
        vcnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (oREQ_VALID) vcnt++;
        end
        chk("stale_no_request", vcnt, 0);
        chk("stale_status", oSTATUS, 32'h8000_0000);
        mon_on = 1'b1;

        // Basic command with immediate ready and response
        rsp_en = 1'b1; rsp_delay = 0; rsp_data = 32'hCAFE_F00D; rsp_stat = 4'h0;
        exp_req.push_back('{op: 8'h05, arg: 32'h1234});
        exp_rsp.push_back('{op: 8'h05, stat: 4'h0, data: 32'hCAFE_F00D});
        send_cmd(8'h05, 32'h1234, tv, ta);
        chk("basic_valid_latency", tv, 5);
        chk("basic_ack_latency", ta, 8);
        chk("basic_result", oRESULT, 32'hCAFE_F00D);
        chk("basic_echo_op", oSTATUS[30:23], 8'h05);

        // Delayed response with non-zero status
        rsp_delay = 3; rsp_data = 32'h1234_5678; rsp_stat = 4'h7;
        exp_req.push_back('{op: 8'hA3, arg: 32'hDEAD_BEEF});
        exp_rsp.push_back('{op: 8'hA3, stat: 4'h7, data: 32'h1234_5678});
        send_cmd(8'hA3, 32'hDEAD_BEEF, tv, ta);
        chk("delayed_ack_latency", ta, 11);
        chk("delayed_code", oSTATUS[3:0], 4'h7);

        // Argument keeps moving during settle; only the final value issues
        rsp_delay = 0; rsp_data = 32'h55AA_55AA; rsp_stat = 4'h1;
        hs0 = hs_cnt;
        exp_req.push_back('{op: 8'h3C, arg: 32'hAA});
        exp_rsp.push_back('{op: 8'h3C, stat: 4'h1, data: 32'h55AA_55AA});
        host_req = ~host_req;
        iCMD = {host_req, 8'h3C, 23'h0};
        iARG = 32'h0;
        for (int k = 0; k < 10; k++) begin
            repeat (2) @(posedge clk);
            #1;
            iARG = 32'h100 + k;
        end
        iARG = 32'hAA;
        wait_ack("unstable_ack_seen");
        chk("unstable_single_request", hs_cnt - hs0, 1);

        // Backpressure: request held steady, host edits after issue ignored
        iREQ_READY = 1'b0;
        rsp_data = 32'h1357_9BDF; rsp_stat = 4'h2;
        hs0 = hs_cnt;
        exp_req.push_back('{op: 8'h77, arg: 32'h0BAD_CAFE});
        exp_rsp.push_back('{op: 8'h77, stat: 4'h2, data: 32'h1357_9BDF});
        host_req = ~host_req;
        iCMD = {host_req, 8'h77, 23'h0};
        iARG = 32'h0BAD_CAFE;
        vcnt = 0;
        for (int i = 0; i < 50 && !oREQ_VALID; i++) begin
            @(posedge clk); #1;
        end
        chk("bp_valid_seen", oREQ_VALID, 1'b1);
        iARG = 32'hFFFF_0000;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (!oREQ_VALID || oREQ_OP != 8'h77 || oREQ_ARG != 32'h0BAD_CAFE) vcnt++;
        end
        chk("bp_request_held", vcnt, 0);
        chk("bp_no_handshake_yet", hs_cnt - hs0, 0);
        iREQ_READY = 1'b1;
        wait_ack("bp_ack_seen");
        chk("bp_single_handshake", hs_cnt - hs0, 1);

        // Reset while waiting for a response; late response must be dropped
        rsp_delay = 2; rsp_data = 32'hBBBB_BBBB; rsp_stat = 4'h3;
        exp_req.push_back('{op: 8'h11, arg: 32'h2222});
        host_req = ~host_req;
        iCMD = {host_req, 8'h11, 23'h0};
        iARG = 32'h2222;
        for (int i = 0; i < 50 && !oREQ_VALID; i++) begin
            @(posedge clk); #1;
        end
        chk("rst_test_valid_seen", oREQ_VALID, 1'b1);
        @(posedge clk); #1;
        mon_on = 1'b0;
        iRESET = 1'b1;
        @(posedge clk); #1;
        iRESET = 1'b0;
        chk("rst_valid_low", oREQ_VALID, 1'b0);
        chk("rst_status_clear", oSTATUS, 32'h0);
        chk("rst_result_clear", oRESULT, 32'h0);
        @(posedge clk); #1;
        chk("rst_resync_status", oSTATUS, {host_req, 31'h0});
        held_ack = oSTATUS[31];
        vcnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (oREQ_VALID || oRESULT != 32'h0 || oSTATUS[31] != held_ack) vcnt++;
        end
        chk("rst_response_dropped", vcnt, 0);
        mon_on = 1'b1;

        // Normal operation resumes after the mid-flight reset
        rsp_delay = 1; rsp_data = 32'h0F0F_0F0F; rsp_stat = 4'h0;
        exp_req.push_back('{op: 8'h42, arg: 32'h4242});
        exp_rsp.push_back('{op: 8'h42, stat: 4'h0, data: 32'h0F0F_0F0F});
        send_cmd(8'h42, 32'h4242, tv, ta);
        chk("recover_ack_latency", ta, 9);

`ifdef JTAG_CMD_TIMEOUT_EN
        // No response at all: timeout result reported
        rsp_en = 1'b0;
        exp_req.push_back('{op: 8'h99, arg: 32'h9});
        exp_rsp.push_back('{op: 8'h99, stat: 4'hE, data: 32'h0});
        send_cmd(8'h99, 32'h9, tv, ta);
        chk("timeout_ack_latency", ta, 8 + 15);
        chk("timeout_code", oSTATUS[3:0], 4'hE);
        chk("timeout_result", oRESULT, 32'h0);

        // Response in the expiry cycle beats the timeout
        rsp_en = 1'b1; rsp_delay = 15; rsp_data = 32'hFACE_B00C; rsp_stat = 4'h5;
        exp_req.push_back('{op: 8'h9A, arg: 32'hA});
        exp_rsp.push_back('{op: 8'h9A, stat: 4'h5, data: 32'hFACE_B00C});
        send_cmd(8'h9A, 32'hA, tv, ta);
        chk("expiry_ack_latency", ta, 8 + 15);
        chk("expiry_code", oSTATUS[3:0], 4'h5);
`endif

        repeat (5) @(posedge clk);
        #1;
        chk("req_queue_drained", exp_req.size(), 0);
        chk("rsp_queue_drained", exp_rsp.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
